// File: rtl/blink_sequencer.sv
// blink_sequencer: plays a programmable table of (period, repeat) entries into the blink datapath.
// Latency: start -> period_load 2 cycles (+1 per skipped entry); final blink_done -> next period_load 2 cycles.
// Backpressure: none; stop pauses playback without a reload, and start resumes it.
//
// Ports:
//   clk, reset                      system clock and synchronous active-high reset
//   wr_en/wr_addr/wr_period/wr_reps table write port (period 0 = skip entry, reps 0 = play once)
//   num_entries                     last active table index
//   start/stop                      playback control pulses (stop wins when both are asserted)
//   blink_done                      one pulse per completed blink, from the datapath
//   period_out/period_load          period and load strobe to the datapath
//   busy/cur_index/loop_count       status
module blink_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int PW    = 14,
    parameter int RW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [PW-1:0] wr_period,
    input  logic [RW-1:0] wr_reps,
    input  logic [AW-1:0] num_entries,
    input  logic          start,
    input  logic          stop,
    input  logic          blink_done,
    output logic [PW-1:0] period_out,
    output logic          period_load,
    output logic          busy,
    output logic [AW-1:0] cur_index,
    output logic [RW-1:0] loop_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEEK  = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] period_out_q, period_out_d;
    logic [AW-1:0] cur_index_q, cur_index_d;
    logic [RW-1:0] loop_count_q, loop_count_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [AW-1:0] seek_cnt_q, seek_cnt_d;
    logic [PW-1:0] tbl_period_q [DEPTH];
    logic [PW-1:0] tbl_period_d [DEPTH];
    logic [RW-1:0] tbl_reps_q   [DEPTH];
    logic [RW-1:0] tbl_reps_d   [DEPTH];

    // Index advance with wrap; ">=" so an index stranded above a shrunken
    // num_entries still wraps to 0 on its next advance.
    logic          last_entry;
    logic [AW-1:0] adv_index;
    logic [RW-1:0] adv_loop;

    always_comb begin
        last_entry = (cur_index_q >= num_entries);
        adv_index  = last_entry ? '0 : cur_index_q + AW'(1);
        adv_loop   = last_entry ? loop_count_q + RW'(1) : loop_count_q;
    end

    // State register (plus datapath and table flops)
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            period_out_q <= '0;
            cur_index_q  <= '0;
            loop_count_q <= '0;
            rep_q        <= '0;
            seek_cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_period_q[i] <= '0;
                tbl_reps_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            period_out_q <= period_out_d;
            cur_index_q  <= cur_index_d;
            loop_count_q <= loop_count_d;
            rep_q        <= rep_d;
            seek_cnt_q   <= seek_cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_period_q[i] <= tbl_period_d[i];
                tbl_reps_q[i]   <= tbl_reps_d[i];
            end
        end
    end

    // Table write port
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tbl_period_d[i] = tbl_period_q[i];
            tbl_reps_d[i]   = tbl_reps_q[i];
        end
        if (wr_en) begin
            tbl_period_d[wr_addr] = wr_period;
            tbl_reps_d[wr_addr]   = wr_reps;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        period_out_d = period_out_q;
        cur_index_d  = cur_index_q;
        loop_count_d = loop_count_q;
        rep_d        = rep_q;
        seek_cnt_d   = seek_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d     = S_SEEK;
                    cur_index_d = '0;
                    seek_cnt_d  = '0;
                end
            end
            S_SEEK: begin
                if (tbl_period_q[cur_index_q] != '0) begin
                    // Period and rep count are captured on entry to LOAD so
                    // period_out is already valid while period_load is high.
                    state_d      = S_LOAD;
                    period_out_d = tbl_period_q[cur_index_q];
                    rep_d        = (tbl_reps_q[cur_index_q] == '0) ? RW'(1)
                                                                   : tbl_reps_q[cur_index_q];
                end else if (seek_cnt_q >= num_entries) begin
                    // Whole active table examined, nothing playable.
                    state_d = S_IDLE;
                end else begin
                    cur_index_d  = adv_index;
                    loop_count_d = adv_loop;
                    seek_cnt_d   = seek_cnt_q + AW'(1);
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (blink_done && rep_q != '0) begin
                    rep_d = rep_q - RW'(1);
                end
                if (stop) begin
                    // Decrement still applies; a rep of 0 left here makes the
                    // first blink_done after resume advance immediately.
                    state_d = S_PAUSE;
                end else if (blink_done && rep_q <= RW'(1)) begin
                    state_d      = S_SEEK;
                    cur_index_d  = adv_index;
                    loop_count_d = adv_loop;
                    seek_cnt_d   = '0;
                end
            end
            S_PAUSE: begin
                if (start && !stop) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        period_out  = period_out_q;
        period_load = (state_q == S_LOAD);
        busy        = (state_q == S_SEEK) || (state_q == S_LOAD) || (state_q == S_RUN);
        cur_index   = cur_index_q;
        loop_count  = loop_count_q;
    end

endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: directed stimulus with a load-event scoreboard for blink_sequencer.
// Latency: expected loads carry the cycle they must appear in.
// Backpressure: n/a; every wait is bounded by a global watchdog.
module tb_blink_sequencer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int PW    = 14;
    localparam int RW    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [PW-1:0] wr_period = '0;
    logic [RW-1:0] wr_reps = '0;
    logic [AW-1:0] num_entries = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          blink_done = 1'b0;
    logic [PW-1:0] period_out;
    logic          period_load;
    logic          busy;
    logic [AW-1:0] cur_index;
    logic [RW-1:0] loop_count;

    blink_sequencer #(.DEPTH(DEPTH), .AW(AW), .PW(PW), .RW(RW)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_period   (wr_period),
        .wr_reps     (wr_reps),
        .num_entries (num_entries),
        .start       (start),
        .stop        (stop),
        .blink_done  (blink_done),
        .period_out  (period_out),
        .period_load (period_load),
        .busy        (busy),
        .cur_index   (cur_index),
        .loop_count  (loop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t_set  = 0;

    typedef struct {
        int period;
        int index;
        int loop;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_load(input int p, input int i, input int l, input int c);
        exp_t e;
        e.period = p;
        e.index  = i;
        e.loop   = l;
        e.cyc    = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every period_load strobe must match the oldest expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (period_load) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load: period_out %0d cur_index %0d at cycle %0d, none expected",
                         period_out, cur_index, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("load_period", int'(period_out), e.period);
                chk("load_index", int'(cur_index), e.index);
                chk("load_loop", int'(loop_count), e.loop);
                chk("load_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_entry(input int a, input int p, input int r);
        @(negedge clk);
        wr_en     = 1'b1;
        wr_addr   = AW'(a);
        wr_period = PW'(p);
        wr_reps   = RW'(r);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        t_set = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop  = 1'b1;
        t_set = cyc;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        blink_done = 1'b1;
        t_set      = cyc;
        @(negedge clk);
        blink_done = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_period_out"}, int'(period_out), 0);
        chk({tag, "_period_load"}, int'(period_load), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_cur_index"}, int'(cur_index), 0);
        chk({tag, "_loop_count"}, int'(loop_count), 0);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_busy;

        // Reset state
        idle(2);
        reset = 1'b0;
        check_outputs_zero("reset");

        // 1) Two-entry table, wrap back to e0 with loop_count 1
        write_entry(0, 500, 2);
        write_entry(1, 1000, 1);
        num_entries = 3'd1;
        pulse_start();
        expect_load(500, 0, 0, t_set + 2);
        idle(4);
        chk("t1_busy_run", int'(busy), 1);
        pulse_done();
        idle(2);
        pulse_done();
        expect_load(1000, 1, 0, t_set + 2);
        idle(4);
        pulse_done();
        expect_load(500, 0, 1, t_set + 2);
        idle(4);

        // 2) Skip two zero-period entries
        do_reset();
        write_entry(2, 250, 3);
        num_entries = 3'd2;
        pulse_start();
        expect_load(250, 2, 0, t_set + 4);
        idle(6);
        chk("t2_cur_index", int'(cur_index), 2);
        chk("t2_busy", int'(busy), 1);

        // 3) Empty table: 8 SEEK cycles then idle, no load
        do_reset();
        num_entries = 3'd7;
        pulse_start();
        t_busy = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!busy) begin
                t_busy = cyc;
                break;
            end
        end
        chk("t3_busy_drop_cycle", t_busy, t_set + 9);
        idle(3);
        chk("t3_still_idle", int'(busy), 0);

        // 4) Pause mid-entry: blink_done ignored while paused, no reload on resume
        do_reset();
        write_entry(0, 100, 3);
        write_entry(1, 200, 1);
        num_entries = 3'd1;
        pulse_start();
        expect_load(100, 0, 0, t_set + 2);
        idle(3);
        pulse_done();
        pulse_stop();
        chk("t4_busy_paused", int'(busy), 0);
        for (int k = 0; k < 5; k++) begin
            pulse_done();
            chk("t4_busy_pause_done", int'(busy), 0);
        end
        chk("t4_period_held", int'(period_out), 100);
        pulse_start();
        chk("t4_busy_resumed", int'(busy), 1);
        pulse_done();
        idle(1);
        pulse_done();
        expect_load(200, 1, 0, t_set + 2);
        idle(4);

        // 5) Write to the playing entry takes effect at its next load; reps=0 plays once
        do_reset();
        write_entry(0, 300, 1);
        write_entry(1, 400, 0);
        num_entries = 3'd1;
        pulse_start();
        expect_load(300, 0, 0, t_set + 2);
        idle(3);
        write_entry(0, 777, 1);
        idle(1);
        chk("t5_period_unchanged", int'(period_out), 300);
        pulse_done();
        expect_load(400, 1, 0, t_set + 2);
        idle(3);
        pulse_done();
        expect_load(777, 0, 1, t_set + 2);
        idle(4);

        // 6) loop_count wraps after 256 passes, then reset mid-RUN
        do_reset();
        write_entry(0, 5, 1);
        num_entries = 3'd0;
        pulse_start();
        expect_load(5, 0, 0, t_set + 2);
        for (int i = 1; i <= 256; i++) begin
            idle(2);
            pulse_done();
            expect_load(5, 0, i % 256, t_set + 2);
        end
        idle(3);
        chk("t6_loop_wrapped", int'(loop_count), 0);
        chk("t6_busy_run", int'(busy), 1);
        do_reset();
        check_outputs_zero("t6_reset_mid_run");
        // Table must be cleared: entry 0 now reads as skip
        pulse_start();
        idle(1);
        chk("t6_table_cleared_busy", int'(busy), 0);
        idle(4);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
Playback controller that drives the period register of the LED blink datapath from a small programmable table.
- Each table entry holds a blink period (ms ticks) and a repeat count.
- The sequencer loads the period, counts completed blinks reported back by the datapath, then advances to the next entry. It wraps after the last entry.
- Sits between the button/switch front end (start/stop/table writes) and the blink counter datapath (period_load/period_out, blink_done).

Parameters:
DEPTH, 8, number of table entries (power of two)
AW, 3, log2(DEPTH), entry index width
PW, 14, period width in ms ticks
RW, 8, repeat count and loop counter width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  table write strobe, single cycle
wr_addr  in  AW  table entry written
wr_period  in  PW  period for entry; 0 marks entry as skip
wr_reps  in  RW  blinks to play for entry; 0 treated as 1
num_entries  in  AW  last active index (active entries 0..num_entries)
start  in  1  single-cycle pulse: begin or resume playback
stop  in  1  single-cycle pulse: pause playback
blink_done  in  1  single-cycle pulse from datapath when its period counter wraps
period_out  out  PW  period presented to datapath
period_load  out  1  single-cycle strobe: datapath latches period_out and restarts its counters
busy  out  1  high in SEEK, LOAD, RUN
cur_index  out  AW  entry currently playing
loop_count  out  RW  completed passes through the table, wraps modulo 2^RW

Behaviour:
- Reset: state=IDLE, period_out=0, period_load=0, busy=0, cur_index=0, loop_count=0, internal rep counter=0, all table entries period=0/reps=0.
- Table: DEPTH x (PW+RW) registers.
  - Write takes effect the cycle after wr_en and is legal in any state.
  - A write to the currently playing entry does not affect the running period. It is used at the next LOAD of that entry.
- States:
  - IDLE: busy=0, outputs hold. start -> SEEK with cur_index=0, loop_count unchanged.
  - SEEK: one cycle per examined entry. If period[cur_index]!=0 -> LOAD. Otherwise advance the index (see wrap rule) and stay in SEEK. If all num_entries+1 entries are examined and all are zero -> IDLE, busy=0, no period_load.
  - LOAD: period_out<=period[cur_index]; period_load=1 for exactly this cycle; rep counter<=max(reps,1); -> RUN.
  - RUN: each blink_done decrements the rep counter.
    - On the blink_done that takes it from 1 to 0: advance the index -> SEEK.
    - stop -> PAUSE. blink_done is ignored in IDLE and PAUSE.
  - PAUSE: busy=0. period_out, cur_index and rep counter held; period_load not asserted. start -> RUN; the datapath keeps its running period and no reload occurs.
- Index advance/wrap: if cur_index==num_entries then cur_index<=0 and loop_count<=loop_count+1 (wraps at 2^RW). Otherwise cur_index+1.
- Latency: start in IDLE -> period_load 2 cycles later when entry 0 is valid (SEEK, LOAD). Final blink_done of an entry -> next period_load 2 cycles later when the next entry is valid, plus 1 cycle per skipped entry.
- Simultaneous events:
  - stop with start: stop wins.
  - stop with final blink_done in RUN: the decrement is applied, the index advance is not, and the state goes to PAUSE. On resume, the next blink_done is counted against rep=0, which the block treats as an immediate advance.
  - reset overrides everything.
- num_entries changed mid-run is sampled at each index advance. A cur_index above the new num_entries wraps to 0 at its next advance.
- stop in IDLE/SEEK/LOAD is ignored. start in RUN/SEEK/LOAD is ignored.
- reset mid-RUN: next cycle the block is in IDLE with all outputs at reset values and the table cleared.

Test Plan:
- Program e0=(500,2), e1=(1000,1), num_entries=1, pulse start -> period_load at +2 cycles with period_out=500. After 2 blink_done: period_load with period_out=1000, cur_index=1. After 1 more blink_done: period_out=500, cur_index=0, loop_count=1.
- e0=(0,x), e1=(0,x), e2=(250,3), num_entries=2, start -> SEEK skips two entries, period_load at +4 cycles with period_out=250, cur_index=2.
- All entries period=0, num_entries=7, start -> no period_load; busy returns to 0 after 8 SEEK cycles; state IDLE.
- In RUN on e0 reps=3: blink_done, stop, then 5 blink_done, then start, then 2 blink_done -> no period_load until the final blink_done; then e1 loads. busy=0 throughout the pause.
- Write e0 period=777 while e0 is playing -> period_out stays at the old value until the next pass through e0 loads 777. reps=0 entry plays exactly 1 blink.
- loop_count wrap: 1 entry, reps=1, 256 blink_done -> loop_count returns to 0. Assert reset mid-RUN -> all outputs 0 next cycle and the table is cleared.
